// File: rtl/lfsr_seq_checker.sv
// Receive-side checker that self-seeds from an 8-bit LFSR stream, verifies lock and flags errors.
// Define LFSR_SEQ_CHECKER_PERIOD_EN to build the sequence-period measurement.
module lfsr_seq_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rnd_in,
    input  logic        rnd_valid,
    input  logic        clr_err,
    output logic        locked,
    output logic [7:0]  expected,
    output logic        match_pulse,
    output logic        err_pulse,
    output logic        zero_pulse,
    output logic [15:0] err_count,
    output logic [8:0]  period,
    output logic        period_valid
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned PER_W  = 9;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Generator recurrence: taps 7,5,4,3 shifted in at the LSB.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic [DATA_W-1:0]  exp_q, exp_d;
    logic               locked_q, locked_d;
    logic               match_q, match_d;
    logic               err_q, err_d;
    logic               zero_q, zero_d;
    logic [ERR_W-1:0]   errc_q, errc_d;

    // Next-state and registered-output logic for the lock state machine.
    always_comb begin
        state_d  = state_q;
        vcnt_d   = vcnt_q;
        miss_d   = miss_q;
        exp_d    = exp_q;
        locked_d = locked_q;
        match_d  = 1'b0;
        err_d    = 1'b0;
        zero_d   = 1'b0;
        errc_d   = errc_q;

        if (rnd_valid) begin
            unique case (state_q)
                ST_SEEK: begin
                    if (rnd_in == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        exp_d   = lfsr_next(rnd_in);
                        vcnt_d  = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (rnd_in == '0) begin
                        zero_d  = 1'b1;
                        state_d = ST_SEEK;
                    end else if (rnd_in == exp_q) begin
                        exp_d = lfsr_next(rnd_in);
                        if ((vcnt_q + CNT_W'(1)) == CNT_W'(LOCK_COUNT)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                            vcnt_d   = '0;
                        end else begin
                            vcnt_d = vcnt_q + CNT_W'(1);
                        end
                    end else begin
                        exp_d  = lfsr_next(rnd_in);
                        vcnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    zero_d = (rnd_in == '0);
                    if (rnd_in == exp_q) begin
                        match_d = 1'b1;
                        miss_d  = '0;
                        exp_d   = lfsr_next(exp_q);
                    end else begin
                        err_d = 1'b1;
                        if (errc_q != '1) begin
                            errc_d = errc_q + ERR_W'(1);
                        end
                        // On loss of lock the prediction freezes at its last value.
                        if ((miss_q + CNT_W'(1)) == CNT_W'(LOSS_COUNT)) begin
                            state_d  = ST_SEEK;
                            locked_d = 1'b0;
                            miss_d   = '0;
                        end else begin
                            miss_d = miss_q + CNT_W'(1);
                            exp_d  = lfsr_next(exp_q);
                        end
                    end
                end
                default: begin
                    state_d  = ST_SEEK;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (clr_err) begin
            errc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_SEEK;
            vcnt_q   <= '0;
            miss_q   <= '0;
            exp_q    <= '0;
            locked_q <= 1'b0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            vcnt_q   <= vcnt_d;
            miss_q   <= miss_d;
            exp_q    <= exp_d;
            locked_q <= locked_d;
            match_q  <= match_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            errc_q   <= errc_d;
        end
    end

    assign locked      = locked_q;
    assign expected    = exp_q;
    assign match_pulse = match_q;
    assign err_pulse   = err_q;
    assign zero_pulse  = zero_q;
    assign err_count   = errc_q;

`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
    localparam logic [PER_W-1:0] PER_MAX = '1;

    logic              enter_lock;
    logic              leave_lock;
    logic [DATA_W-1:0] ref_q, ref_d;
    logic [PER_W-1:0]  pcnt_q, pcnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              pvalid_q, pvalid_d;

    assign enter_lock = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
    assign leave_lock = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);

    // Reference is the sample that completed lock; its next recurrence closes one period.
    always_comb begin
        ref_d    = ref_q;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        pvalid_d = pvalid_q;
        if (enter_lock) begin
            ref_d  = exp_q;
            pcnt_d = '0;
        end else if (leave_lock) begin
            pvalid_d = 1'b0;
        end else if (match_d) begin
            if (rnd_in == ref_q) begin
                period_d = (pcnt_q == PER_MAX) ? PER_MAX : pcnt_q + PER_W'(1);
                pvalid_d = 1'b1;
                pcnt_d   = '0;
            end else if (pcnt_q != PER_MAX) begin
                pcnt_d = pcnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_q    <= '0;
            pcnt_q   <= '0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pvalid_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: vector table, directed corner sequences, random stream vs model.
module tb_lfsr_seq_checker;

    localparam int unsigned LOCK_N = 4;
    localparam int unsigned LOSS_N = 3;
`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  rnd_in;
    logic        rnd_valid;
    logic        clr_err;
    logic        locked;
    logic [7:0]  expected;
    logic        match_pulse;
    logic        err_pulse;
    logic        zero_pulse;
    logic [15:0] err_count;
    logic [8:0]  period;
    logic        period_valid;

    lfsr_seq_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
        .clk(clk), .reset(reset), .rnd_in(rnd_in), .rnd_valid(rnd_valid), .clr_err(clr_err),
        .locked(locked), .expected(expected), .match_pulse(match_pulse), .err_pulse(err_pulse),
        .zero_pulse(zero_pulse), .err_count(err_count), .period(period), .period_valid(period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Sequence table: seq_tab[i] is the i-th nonzero value of the orbit, pos_tab maps back.
    int seq_tab[255];
    int pos_tab[256];

    function automatic int pred(input int v);
        if (v == 0) return 0;
        return seq_tab[(pos_tab[v] + 1) % 255];
    endfunction

    // Reference model state (mode: 0 searching, 1 confirming, 2 locked).
    int m_mode, m_exp, m_vcnt, m_miss, m_err, m_ref, m_pcnt, m_period;
    bit m_lock, m_match, m_errp, m_zero, m_pv;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_vcnt = 0; m_miss = 0; m_err = 0;
        m_ref = 0; m_pcnt = 0; m_period = 0;
        m_lock = 0; m_match = 0; m_errp = 0; m_zero = 0; m_pv = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c);
        m_match = 0; m_errp = 0; m_zero = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d == 0) m_zero = 1;
                else begin m_exp = pred(d); m_vcnt = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == 0) begin m_zero = 1; m_mode = 0; end
                else if (d == m_exp) begin
                    m_exp = pred(d);
                    m_vcnt++;
                    if (m_vcnt == LOCK_N) begin
                        m_mode = 2; m_lock = 1; m_miss = 0; m_ref = d; m_pcnt = 0;
                    end
                end else begin
                    m_exp = pred(d); m_vcnt = 0;
                end
            end else begin
                if (d == 0) m_zero = 1;
                if (d == m_exp) begin
                    m_match = 1; m_miss = 0; m_exp = pred(m_exp);
                    if (d == m_ref) begin
                        m_period = (m_pcnt + 1 > 511) ? 511 : m_pcnt + 1;
                        m_pv = 1; m_pcnt = 0;
                    end else if (m_pcnt < 511) m_pcnt++;
                end else begin
                    m_errp = 1;
                    if (m_err < 65535) m_err++;
                    m_miss++;
                    if (m_miss == LOSS_N) begin
                        m_mode = 0; m_lock = 0; m_miss = 0; m_pv = 0;
                    end else m_exp = pred(m_exp);
                end
            end
        end
        if (c) m_err = 0;
    endtask

    task automatic chk_model();
        chk("locked", int'(locked), int'(m_lock));
        chk("expected", int'(expected), m_exp);
        chk("match_pulse", int'(match_pulse), int'(m_match));
        chk("err_pulse", int'(err_pulse), int'(m_errp));
        chk("zero_pulse", int'(zero_pulse), int'(m_zero));
        chk("err_count", int'(err_count), m_err);
        chk("period", int'(period), PER_EN ? m_period : 0);
        chk("period_valid", int'(period_valid), PER_EN ? int'(m_pv) : 0);
    endtask

    // One clock: drive, take the edge, advance the model, compare 1 time unit later.
    task automatic step(input bit v, input logic [7:0] d, input bit c);
        rnd_valid = v; rnd_in = d; clr_err = c;
        @(posedge clk);
        model_step(v, int'(d), c);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        reset = 1'b0; rnd_valid = 1'b0; rnd_in = '0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_locked", int'(locked), 0);
        chk("rst_expected", int'(expected), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_pulses", int'({match_pulse, err_pulse, zero_pulse}), 0);
        chk("rst_period", int'({period_valid, period}), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          c;
        bit          lk;
        logic [7:0]  ex;
        bit          mp;
        bit          ep;
        bit          zp;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int x;
        int cur;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            seq_tab[i] = x;
            pos_tab[x] = i;
            x = ((x * 2) % 256) + (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
        end
        pos_tab[0] = 0;

        tbl[0]  = '{1'b1, 8'd13,   1'b0, 1'b0, 8'd27,  1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 8'd27,   1'b0, 1'b0, 8'd54,  1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 8'd54,   1'b0, 1'b0, 8'd108, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 8'd108,  1'b0, 1'b0, 8'd216, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 8'd216,  1'b0, 1'b1, 8'd177, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 8'h77,   1'b0, 1'b1, 8'd177, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 8'd177,  1'b0, 1'b1, 8'd99,  1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 8'h55,   1'b0, 1'b1, 8'd199, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[8]  = '{1'b1, 8'd199,  1'b0, 1'b1, 8'd143, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[9]  = '{1'b1, 8'd143,  1'b0, 1'b1, 8'd30,  1'b1, 1'b0, 1'b0, 16'd1};
        tbl[10] = '{1'b1, 8'h55,   1'b0, 1'b1, 8'd60,  1'b0, 1'b1, 1'b0, 16'd2};
        tbl[11] = '{1'b1, 8'h55,   1'b0, 1'b1, 8'd121, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[12] = '{1'b1, 8'h55,   1'b0, 1'b0, 8'd121, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[13] = '{1'b1, 8'h00,   1'b0, 1'b0, 8'd121, 1'b0, 1'b0, 1'b1, 16'd4};
        tbl[14] = '{1'b1, 8'd5,    1'b0, 1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 16'd4};
        tbl[15] = '{1'b1, 8'h00,   1'b0, 1'b0, 8'd10,  1'b0, 1'b0, 1'b1, 16'd4};
        tbl[16] = '{1'b1, 8'd10,   1'b0, 1'b0, 8'd21,  1'b0, 1'b0, 1'b0, 16'd4};
        tbl[17] = '{1'b0, 8'h00,   1'b1, 1'b0, 8'd21,  1'b0, 1'b0, 1'b0, 16'd0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("vec%0d_expected", i), int'(expected), int'(tbl[i].ex));
            chk($sformatf("vec%0d_pulses", i), int'({match_pulse, err_pulse, zero_pulse}),
                int'({tbl[i].mp, tbl[i].ep, tbl[i].zp}));
            chk($sformatf("vec%0d_err_count", i), int'(err_count), int'(tbl[i].ec));
        end

        // Build err_count to 5 without losing lock, then clear and mismatch together.
        do_reset();
        cur = 13;
        for (int i = 0; i < 5; i++) begin step(1'b1, 8'(cur), 1'b0); cur = pred(cur); end
        chk("lock_after_five", int'(locked), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h55, 1'b0); cur = pred(cur);
            step(1'b1, 8'(cur), 1'b0); cur = pred(cur);
        end
        chk("errcnt_five", int'(err_count), 5);
        chk("still_locked", int'(locked), 1);
        step(1'b1, 8'h55, 1'b1);
        chk("clr_wins_count", int'(err_count), 0);
        chk("clr_wins_pulse", int'(err_pulse), 1);
        chk("clr_wins_locked", int'(locked), 1);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_expected", int'(expected), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Long clean stream for the period measurement.
        cur = 13;
        for (int i = 0; i < 300; i++) begin step(1'b1, 8'(cur), 1'b0); cur = pred(cur); end
        chk("period_valid_long", int'(period_valid), PER_EN ? 1 : 0);
        chk("period_long", int'(period), PER_EN ? 255 : 0);
        chk("long_err_count", int'(err_count), 0);

        // Random stream: mostly on-sequence, with corruptions, zeros, resyncs, gaps and clears.
        do_reset();
        cur = 1 + int'($urandom_range(254));
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit v;
            bit c;
            logic [7:0] d;
            v = ($urandom_range(7) != 0);
            c = ($urandom_range(49) == 0);
            r = int'($urandom_range(99));
            d = 8'(cur);
            if (v) begin
                if (r < 82) begin
                    d = 8'(cur); cur = pred(cur);
                end else if (r < 90) begin
                    d = 8'($urandom_range(255)); cur = pred(cur);
                end else if (r < 94) begin
                    d = 8'h00;
                end else begin
                    cur = 1 + int'($urandom_range(254));
                    d = 8'(cur); cur = pred(cur);
                end
            end
            step(v, d, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
